// File: rtl/rbs_serial_sub.sv
// Bit-serial ripple-borrow subtractor: diff = {borrow, A - B - Bin}, one bit per clock, LSB first.
// Latency: start sampled at edge t, result and done pulse valid after edge t+N; one op per N+2 cycles.
// Backpressure: none; start is only honoured in IDLE and ignored (not queued) in RUN/DONE.
module rbs_serial_sub #(
  parameter int N     = 20,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N:0]   diff,
  output logic         borrow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       ash_q, ash_d;
  logic [N-1:0]       bsh_q, bsh_d;
  logic [N-1:0]       res_q, res_d;
  logic [N:0]         diff_q, diff_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic a_bit, b_bit, d_bit, br_nxt;

  // One full-subtractor cell applied to the current LSBs of the operand shifters.
  always_comb begin
    a_bit  = ash_q[0];
    b_bit  = bsh_q[0];
    d_bit  = a_bit ^ b_bit ^ br_q;
    br_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  // Next-state logic; diff only changes on the final RUN edge so it holds across a new RUN.
  always_comb begin
    state_d = state_q;
    ash_d   = ash_q;
    bsh_d   = bsh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ash_d   = A;
          bsh_d   = B;
          br_d    = Bin;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        ash_d = ash_q >> 1;
        bsh_d = bsh_q >> 1;
        br_d  = br_nxt;
        res_d = {d_bit, res_q[N-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = S_DONE;
          diff_d  = {br_nxt, d_bit, res_q[N-1:1]};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ash_q   <= '0;
      bsh_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ash_q   <= ash_d;
      bsh_q   <= bsh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = diff_q[N];

endmodule

// File: tb/tb_rbs_serial_sub.sv
// Directed bench for rbs_serial_sub with N=20.
module tb_rbs_serial_sub;

  localparam int N = 20;
  localparam int LAT = N + 1;   // edges from the start-sampling edge to done visible

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  a_s, b_s;
  logic          bin_s;
  logic          busy, done, borrow;
  logic [N:0]    diff;

  int errors = 0;
  int checks = 0;

  rbs_serial_sub #(.N(N), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (a_s),
    .B      (b_s),
    .Bin    (bin_s),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N:0] ref_diff(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    ref_diff = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
  endfunction

  // Launch one operation and wait (bounded) for done; lat counts edges incl. the start edge.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin, output int lat);
    @(negedge clk);
    a_s = a; b_s = b; bin_s = bin; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic bin, input logic [N:0] exp_d, input logic exp_br);
    int lat;
    run_op(a, b, bin, lat);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, LAT); end
    checks++;
    if (diff !== exp_d) begin errors++; $display("FAIL %s diff got %h want %h", name, diff, exp_d); end
    checks++;
    if (borrow !== exp_br) begin errors++; $display("FAIL %s borrow got %b want %b", name, borrow, exp_br); end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a_s = '0; b_s = '0; bin_s = 1'b0;
    #12;
    checks++;
    if ({busy, done, borrow, diff} !== '0) begin
      errors++; $display("FAIL reset outputs got busy=%b done=%b borrow=%b diff=%h want all 0", busy, done, borrow, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset idle got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_arith;
    check_op("t1_100_37",  20'd100,   20'd37,    1'b0, 21'd63,       1'b0);
    check_op("t2_0_1",     20'd0,     20'd1,     1'b0, 21'h1FFFFF,   1'b1);
    check_op("t3_max_bin", 20'hFFFFF, 20'd0,     1'b1, 21'h0FFFFE,   1'b0);
    check_op("t3_eq_bin",  20'h55555, 20'h55555, 1'b1, 21'h1FFFFF,   1'b1);
    check_op("max_minus_max", 20'hFFFFF, 20'hFFFFF, 1'b0, 21'h000000, 1'b0);
    check_op("zero_minus_max_bin", 20'd0, 20'hFFFFF, 1'b1, 21'h100000, 1'b1);
  endtask

  // Second start during RUN is dropped; diff keeps the previous result until completion.
  task automatic test_ignore_start;
    int dones = 0;
    @(negedge clk);
    a_s = 20'd9; b_s = 20'd4; bin_s = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t4 busy mid-run got %b want 1", busy); end
    checks++;
    if (diff !== 21'h100000) begin errors++; $display("FAIL t4 diff held got %h want 100000", diff); end
    a_s = 20'd1; b_s = 20'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_s = 20'd3; b_s = 20'd8;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL t4 done count got %0d want 1", dones); end
    checks++;
    if (diff !== 21'd5) begin errors++; $display("FAIL t4 diff got %h want 5", diff); end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    @(negedge clk);
    a_s = 20'd500; b_s = 20'd3; bin_s = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, borrow, diff} !== '0) begin
      errors++; $display("FAIL t5 abort outputs got busy=%b done=%b borrow=%b diff=%h want all 0", busy, done, borrow, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL t5 activity after abort got %0d cycles want 0", dones); end
    check_op("t5_7_7", 20'd7, 20'd7, 1'b0, 21'd0, 1'b0);
  endtask

  // start held high; new operands presented each time done is seen, captured two edges later.
  task automatic test_back_to_back;
    logic [N:0] exp_d;
    int cyc = 0, last_done = -1, got = 0, guard = 0;
    @(negedge clk);
    a_s = 20'($urandom); b_s = 20'($urandom); bin_s = 1'($urandom);
    exp_d = ref_diff(a_s, b_s, bin_s);
    start = 1'b1;
    while (got < 400 && guard < 20000) begin
      @(negedge clk);
      cyc++; guard++;
      if (done) begin
        checks++;
        if (diff !== exp_d || borrow !== exp_d[N]) begin
          errors++; $display("FAIL t6 op %0d diff got %h want %h", got, diff, exp_d);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done !== N + 2) begin
            errors++; $display("FAIL t6 done spacing got %0d want %0d", cyc - last_done, N + 2);
          end
        end
        last_done = cyc;
        got++;
        case (got % 4)
          0: begin a_s = 20'($urandom); b_s = 20'($urandom); end
          1: begin a_s = 20'($urandom_range(0, 15)); b_s = 20'($urandom); end
          2: begin a_s = 20'hFFFFF; b_s = 20'($urandom); end
          default: begin a_s = 20'($urandom); a_s = a_s; b_s = a_s; end
        endcase
        bin_s = 1'($urandom);
        exp_d = ref_diff(a_s, b_s, bin_s);
      end
    end
    start = 1'b0;
    checks++;
    if (got !== 400) begin errors++; $display("FAIL t6 completed ops got %0d want 400", got); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
